// File: rtl/coverfloat_pkg.sv
// coverfloat_pkg: field widths, bit offsets, flag indices and packed layout of a coverfloat cover vector
package coverfloat_pkg;

    localparam int OP_W   = 32;
    localparam int RM_W   = 8;
    localparam int OPND_W = 128;
    localparam int FMT_W  = 8;
    localparam int FLAG_W = 8;
    localparam int IX_W   = 32;
    localparam int IM_W   = 192;
    localparam int VEC_W  = OP_W + RM_W + 4*OPND_W + 2*FMT_W + FLAG_W + 4 + IX_W + IM_W;

    // LSB position of each field inside the packed vector
    localparam int IM_L   = 0;
    localparam int IX_L   = IM_L + IM_W;
    localparam int S_L    = IX_L + IX_W;
    localparam int EXC_L  = S_L + 4;
    localparam int RFMT_L = EXC_L + FLAG_W;
    localparam int RES_L  = RFMT_L + FMT_W;
    localparam int OFMT_L = RES_L + OPND_W;
    localparam int C_L    = OFMT_L + FMT_W;
    localparam int B_L    = C_L + OPND_W;
    localparam int A_L    = B_L + OPND_W;
    localparam int RM_L   = A_L + OPND_W;
    localparam int OP_L   = RM_L + RM_W;

    // MSB position of each field
    localparam int IM_H   = IX_L - 1;
    localparam int IX_H   = S_L - 1;
    localparam int S_H    = EXC_L - 1;
    localparam int EXC_H  = RFMT_L - 1;
    localparam int RFMT_H = RES_L - 1;
    localparam int RES_H  = OFMT_L - 1;
    localparam int OFMT_H = C_L - 1;
    localparam int C_H    = B_L - 1;
    localparam int B_H    = A_L - 1;
    localparam int A_H    = RM_L - 1;
    localparam int RM_H   = OP_L - 1;
    localparam int OP_H   = VEC_W - 1;

    // exception_bits positions
    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RM_W-1:0]   rm;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] c;
        logic [FMT_W-1:0]  operand_fmt;
        logic [OPND_W-1:0] result;
        logic [FMT_W-1:0]  result_fmt;
        logic [FLAG_W-1:0] exception_bits;
        logic [2:0]        sign_pad;
        logic              interm_s;
        logic [IX_W-1:0]   interm_x;
        logic [IM_W-1:0]   interm_m;
    } cover_vec_t;

endpackage

// File: rtl/coverfloat_interface.sv
// coverfloat_interface: registered unpacker of cover vectors into named fields with sample strobe and vector counter
// Ports: clk, rst_n (async active-low); vec_valid/vec_in carry one packed vector per cycle;
// op, rm, a, b, c, operand_fmt, result, result_fmt, exception_bits, interm_s/x/m are the held fields;
// flag_nv..flag_nx decode exception_bits; sample_valid pulses the cycle after capture; vector_count counts captures.
module coverfloat_interface
    import coverfloat_pkg::*;
#(
    parameter int OP_W   = 32,
    parameter int RM_W   = 8,
    parameter int OPND_W = 128,
    parameter int FMT_W  = 8,
    parameter int FLAG_W = 8,
    parameter int IX_W   = 32,
    parameter int IM_W   = 192,
    localparam int VEC_W = OP_W + RM_W + 4*OPND_W + 2*FMT_W + FLAG_W + 4 + IX_W + IM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vec_valid,
    input  logic [VEC_W-1:0]  vec_in,
    output logic [OP_W-1:0]   op,
    output logic [RM_W-1:0]   rm,
    output logic [OPND_W-1:0] a,
    output logic [OPND_W-1:0] b,
    output logic [OPND_W-1:0] c,
    output logic [FMT_W-1:0]  operand_fmt,
    output logic [OPND_W-1:0] result,
    output logic [FMT_W-1:0]  result_fmt,
    output logic [FLAG_W-1:0] exception_bits,
    output logic              flag_nv,
    output logic              flag_dz,
    output logic              flag_of,
    output logic              flag_uf,
    output logic              flag_nx,
    output logic              interm_s,
    output logic [IX_W-1:0]   interm_x,
    output logic [IM_W-1:0]   interm_m,
    output logic              sample_valid,
    output logic [31:0]       vector_count
);

    localparam int IXL = IM_W;
    localparam int SL  = IXL + IX_W;
    localparam int EL  = SL + 4;
    localparam int RFL = EL + FLAG_W;
    localparam int RSL = RFL + FMT_W;
    localparam int OFL = RSL + OPND_W;
    localparam int CL  = OFL + FMT_W;
    localparam int BL  = CL + OPND_W;
    localparam int AL  = BL + OPND_W;
    localparam int RML = AL + OPND_W;
    localparam int OPL = RML + RM_W;

    // upper three bits of the sign nibble carry no information
    logic unused_nib;
    assign unused_nib = ^vec_in[SL+3:SL+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op             <= '0;
            rm             <= '0;
            a              <= '0;
            b              <= '0;
            c              <= '0;
            operand_fmt    <= '0;
            result         <= '0;
            result_fmt     <= '0;
            exception_bits <= '0;
            interm_s       <= 1'b0;
            interm_x       <= '0;
            interm_m       <= '0;
            sample_valid   <= 1'b0;
            vector_count   <= '0;
        end else begin
            sample_valid <= vec_valid;
            if (vec_valid) begin
                op             <= vec_in[OPL +: OP_W];
                rm             <= vec_in[RML +: RM_W];
                a              <= vec_in[AL +: OPND_W];
                b              <= vec_in[BL +: OPND_W];
                c              <= vec_in[CL +: OPND_W];
                operand_fmt    <= vec_in[OFL +: FMT_W];
                result         <= vec_in[RSL +: OPND_W];
                result_fmt     <= vec_in[RFL +: FMT_W];
                exception_bits <= vec_in[EL +: FLAG_W];
                interm_s       <= vec_in[SL];
                interm_x       <= vec_in[IXL +: IX_W];
                interm_m       <= vec_in[0 +: IM_W];
                vector_count   <= vector_count + 32'd1;
            end
        end
    end

    assign flag_nv = exception_bits[NV];
    assign flag_dz = exception_bits[DZ];
    assign flag_of = exception_bits[OF];
    assign flag_uf = exception_bits[UF];
    assign flag_nx = exception_bits[NX];

endmodule

// File: tb/tb_coverfloat_interface.sv
// tb_coverfloat_interface: scoreboard bench for coverfloat_interface
module tb_coverfloat_interface;

    localparam int VW = 804;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           vec_valid = 1'b0;
    logic [VW-1:0]  vec_in = '0;
    logic [31:0]    op;
    logic [7:0]     rm;
    logic [127:0]   a, b, c, result;
    logic [7:0]     operand_fmt, result_fmt, exception_bits;
    logic           flag_nv, flag_dz, flag_of, flag_uf, flag_nx;
    logic           interm_s;
    logic [31:0]    interm_x;
    logic [191:0]   interm_m;
    logic           sample_valid;
    logic [31:0]    vector_count;

    coverfloat_interface dut (
        .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_in(vec_in),
        .op(op), .rm(rm), .a(a), .b(b), .c(c), .operand_fmt(operand_fmt),
        .result(result), .result_fmt(result_fmt), .exception_bits(exception_bits),
        .flag_nv(flag_nv), .flag_dz(flag_dz), .flag_of(flag_of), .flag_uf(flag_uf), .flag_nx(flag_nx),
        .interm_s(interm_s), .interm_x(interm_x), .interm_m(interm_m),
        .sample_valid(sample_valid), .vector_count(vector_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  op;
        logic [7:0]   rm;
        logic [127:0] a, b, c;
        logic [7:0]   ofmt;
        logic [127:0] res;
        logic [7:0]   rfmt, exc;
        logic [3:0]   nib;
        logic [31:0]  ix;
        logic [191:0] im;
    } fld_t;

    fld_t        q[$];
    logic [31:0] qc[$];
    fld_t        cur, zero_f, f;
    logic [31:0] cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic fld_t rnd();
        fld_t r;
        r.op = $urandom; r.rm = 8'($urandom);
        r.a = r128(); r.b = r128(); r.c = r128();
        r.ofmt = 8'($urandom); r.res = r128(); r.rfmt = 8'($urandom); r.exc = 8'($urandom);
        r.nib = 4'($urandom); r.ix = $urandom; r.im = {r128(), $urandom, $urandom};
        return r;
    endfunction

    task automatic check_fields(input string t, input fld_t e, input logic [31:0] ec);
        check({t, ".op"}, 256'(op), 256'(e.op));
        check({t, ".rm"}, 256'(rm), 256'(e.rm));
        check({t, ".a"}, 256'(a), 256'(e.a));
        check({t, ".b"}, 256'(b), 256'(e.b));
        check({t, ".c"}, 256'(c), 256'(e.c));
        check({t, ".operand_fmt"}, 256'(operand_fmt), 256'(e.ofmt));
        check({t, ".result"}, 256'(result), 256'(e.res));
        check({t, ".result_fmt"}, 256'(result_fmt), 256'(e.rfmt));
        check({t, ".exception_bits"}, 256'(exception_bits), 256'(e.exc));
        check({t, ".flags"}, 256'({flag_nv, flag_dz, flag_of, flag_uf, flag_nx}),
              256'({e.exc[4], e.exc[3], e.exc[2], e.exc[1], e.exc[0]}));
        check({t, ".interm_s"}, 256'(interm_s), 256'(e.nib[0]));
        check({t, ".interm_x"}, 256'(interm_x), 256'(e.ix));
        check({t, ".interm_m"}, 256'(interm_m), 256'(e.im));
        check({t, ".vector_count"}, 256'(vector_count), 256'(ec));
    endtask

    // drive one cycle; accepted vectors go to the scoreboard and are checked one cycle later
    task automatic step(input string t, input logic v, input fld_t x);
        logic [31:0] ec;
        vec_valid = v;
        vec_in = {x.op, x.rm, x.a, x.b, x.c, x.ofmt, x.res, x.rfmt, x.exc, x.nib, x.ix, x.im};
        if (v) begin
            cnt = cnt + 32'd1;
            q.push_back(x);
            qc.push_back(cnt);
        end
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        check({t, ".sample_valid"}, 256'(sample_valid), 256'(v));
        ec = cnt;
        if (v) begin
            if (q.size() == 0) begin
                check({t, ".scoreboard_empty"}, 256'(1), 256'(0));
            end else begin
                cur = q.pop_front();
                ec = qc.pop_front();
            end
        end
        check_fields(t, cur, ec);
    endtask

    initial begin
        zero_f = '{default: 0};
        cur = zero_f;
        cnt = '0;
        // reset holds everything at zero even with valid all-ones input
        vec_in = '1;
        vec_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.sample_valid", 256'(sample_valid), 256'(0));
        check_fields("reset", zero_f, 32'd0);
        vec_valid = 1'b0;
        rst_n = 1'b1;

        f = zero_f;
        f.op = 32'h10; f.rm = 8'h01; f.a = 128'h3F800000; f.b = 128'h40000000;
        f.res = 128'h40400000; f.exc = 8'h01;
        step("single", 1'b1, f);
        step("single_drop", 1'b0, rnd());

        f = rnd(); f.nib = 4'hF;
        step("nib_f", 1'b1, f);
        f = rnd(); f.nib = 4'hE;
        step("nib_e", 1'b1, f);

        for (int i = 0; i < 5; i++) step("hold", 1'b0, rnd());

        for (int i = 0; i < 3; i++) step("stream", 1'b1, rnd());
        step("stream_end", 1'b0, rnd());

        force dut.vector_count = 32'hFFFF_FFFF;
        #1;
        release dut.vector_count;
        cnt = 32'hFFFF_FFFF;
        check("wrap.preset", 256'(vector_count), 256'(32'hFFFF_FFFF));
        step("wrap", 1'b1, rnd());

        // reset asserted between edges while a vector is being presented
        step("pre_rst", 1'b1, rnd());
        vec_valid = 1'b1;
        vec_in = '1;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        qc.delete();
        cur = zero_f;
        cnt = '0;
        check("async_rst.sample_valid", 256'(sample_valid), 256'(0));
        check_fields("async_rst", zero_f, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 1'b1, rnd());
        step("post_rst2", 1'b1, rnd());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
